seq_alu: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit four-operation ALU. It accepts one operation at a time over a valid/ready input channel and computes it in a single cycle, or iteratively for multiply. It returns a double-width result with status flags over a valid/ready output channel that tolerates backpressure. It sits between the bus-side command decoder and the result sink of the datapath test harnesses.

---
 rtl/seq_alu.sv | 146 ++++++++++++++
 tb/tb_seq_alu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU with single-cycle ops and iterative shift-add multiply
`timescale 1ns/1ps

module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [2:0]           op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 zero,
   output logic                 err
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_MUL = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_HOLD
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 err_q, err_d;

   logic                 accept;
   logic [WIDTH:0]       sum_w;
   logic [WIDTH:0]       diff_w;
   logic [2*WIDTH-1:0]   calc_res;
   logic                 calc_err;
   logic [2*WIDTH-1:0]   partial;
   logic [2*WIDTH-1:0]   acc_next;

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
   assign out_valid = (state_q == S_HOLD);
   assign accept    = in_valid && in_ready;
   assign result    = result_q;
   assign zero      = zero_q;
   assign err       = err_q;

   // Extra top bit carries the carry (ADD) or the borrow (SUB, modulo 2^(WIDTH+1)).
   assign sum_w  = {1'b0, a} + {1'b0, b};
   assign diff_w = {1'b0, a} - {1'b0, b};

   assign partial  = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
   assign acc_next = acc_q + partial;

   always_comb begin
      calc_res = '0;
      calc_err = 1'b0;
      case (op)
         OP_ADD:  calc_res = {{(WIDTH-1){1'b0}}, sum_w};
         OP_SUB:  calc_res = {{(WIDTH-1){1'b0}}, diff_w};
         OP_XOR:  calc_res = {{WIDTH{1'b0}}, a ^ b};
         OP_AND:  calc_res = {{WIDTH{1'b0}}, a & b};
         OP_OR:   calc_res = {{WIDTH{1'b0}}, a | b};
         OP_MUL:  calc_res = '0;
         default: calc_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      result_d = result_q;
      zero_d   = zero_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE, S_HOLD: begin
            if (accept) begin
               a_d = a;
               b_d = b;
               if (op == OP_MUL) begin
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = S_MUL;
               end else begin
                  result_d = calc_res;
                  zero_d   = (calc_res == '0);
                  err_d    = calc_err;
                  state_d  = S_HOLD;
               end
            end else if ((state_q == S_HOLD) && out_ready) begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            acc_d = acc_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               result_d = acc_next;
               zero_d   = (acc_next == '0);
               err_d    = 1'b0;
               state_d  = S_HOLD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu (WIDTH=8)
`timescale 1ns/1ps

module tb_seq_alu;

   localparam int W = 8;

   logic            clock;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic [2:0]      op;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  result;
   logic            zero;
   logic            err;

   int checks;
   int errors;

   seq_alu #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .err       (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic drive(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
      in_valid = 1'b1;
      op       = o;
      a        = av;
      b        = bv;
   endtask

   task automatic test_reset;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a = '0; b = '0; op = '0;
      repeat (2) @(negedge clock);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || zero !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b vld=%b res=%h z=%b e=%b want rdy=1 vld=0 res=0000 z=0 e=0",
                  in_ready, out_valid, result, zero, err);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_add;
      drive(3'd0, 8'd200, 8'd100);
      @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h012C || zero !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL add_200_100: vld=%b res=%h z=%b e=%b want vld=1 res=012c z=0 e=0", out_valid, result, zero, err);
      end
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_consumed: vld=%b want 0", out_valid);
      end
   endtask

   task automatic test_sub;
      drive(3'd1, 8'd5, 8'd7);
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h01FE || zero !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL sub_borrow: vld=%b res=%h z=%b e=%b want vld=1 res=01fe z=0 e=0", out_valid, result, zero, err);
      end
      drive(3'd1, 8'd9, 8'd9);
      @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h0000 || zero !== 1'b1) begin
         errors++;
         $display("FAIL sub_equal: vld=%b res=%h z=%b want vld=1 res=0000 z=1", out_valid, result, zero);
      end
      @(negedge clock);
   endtask

   task automatic test_mul;
      int busy_bad;
      busy_bad = 0;
      drive(3'd3, 8'd255, 8'd255);
      @(negedge clock);
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
         if (k < 7) @(negedge clock);
      end
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL mul_busy: %0d of 8 cycles had rdy or vld high, want 0", busy_bad);
      end
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || result !== 16'hFE01 || zero !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL mul_255_255: vld=%b res=%h z=%b e=%b want vld=1 res=fe01 z=0 e=0", out_valid, result, zero, err);
      end
      drive(3'd3, 8'd0, 8'd77);
      @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mul_swap_drop: vld=%b want 0", out_valid);
      end
      repeat (8) @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h0000 || zero !== 1'b1) begin
         errors++;
         $display("FAIL mul_zero: vld=%b res=%h z=%b want vld=1 res=0000 z=1", out_valid, result, zero);
      end
      @(negedge clock);
   endtask

   task automatic test_backpressure;
      int unstable;
      unstable  = 0;
      out_ready = 1'b0;
      drive(3'd2, 8'hF0, 8'h3C);
      @(negedge clock);
      drive(3'd4, 8'hF0, 8'h3C);
      for (int k = 0; k < 5; k++) begin
         if (out_valid !== 1'b1 || result !== 16'h00CC || in_ready !== 1'b0 || zero !== 1'b0) unstable++;
         @(negedge clock);
      end
      checks++;
      if (unstable != 0) begin
         errors++;
         $display("FAIL xor_hold: %0d of 5 cycles unstable, last res=%h want 00cc held with rdy=0", unstable, result);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_ready: rdy=%b want 1", in_ready);
      end
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h0030) begin
         errors++;
         $display("FAIL and_swap: vld=%b res=%h want vld=1 res=0030", out_valid, result);
      end
   endtask

   task automatic test_illegal;
      drive(3'd7, 8'd3, 8'd4);
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h0000 || zero !== 1'b1 || err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_op: vld=%b res=%h z=%b e=%b want vld=1 res=0000 z=1 e=1", out_valid, result, zero, err);
      end
      drive(3'd5, 8'h0F, 8'hF0);
      @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h00FF || zero !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL or_after_illegal: vld=%b res=%h z=%b e=%b want vld=1 res=00ff z=0 e=0", out_valid, result, zero, err);
      end
   endtask

   task automatic test_reset_mid_mul;
      int pulses;
      pulses = 0;
      drive(3'd3, 8'd255, 8'd255);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (4) @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || zero !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: rdy=%b vld=%b res=%h z=%b e=%b want rdy=1 vld=0 res=0000 z=0 e=0",
                  in_ready, out_valid, result, zero, err);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (out_valid !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL abandoned_mul: %0d cycles with vld=1 after reset, want 0", pulses);
      end
      drive(3'd0, 8'd1, 8'd1);
      @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h0002 || zero !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL add_after_reset: vld=%b res=%h z=%b e=%b want vld=1 res=0002 z=0 e=0", out_valid, result, zero, err);
      end
      @(negedge clock);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_backpressure();
      test_illegal();
      test_reset_mid_mul();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
